kgp_instr_encoder: RTL and testbench
====================================

# kgp_instr_encoder

Instruction encoder/loader for KGP-RISC: the inverse of the control decoder. It accepts symbolic instructions (mnemonic code plus register and immediate operands) over a valid/ready stream and packs each one into a 32-bit instruction word with the opcode/functcode values the decoder expects. It then writes the word into instruction memory at consecutive addresses from a programmable base. It sits between the test/boot host and the instruction memory write port.

## Interface
- AW, 10, instruction memory address width (depth 2^AW words)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begin a load session at base_addr
- base_addr  in  AW  first write address, sampled on start
- in_valid  in  1  instruction operands valid
- in_ready  out  1  encoder accepts this cycle
- in_mnem  in  5  mnemonic code, see Operation
- in_rs  in  5  rs field
- in_rt  in  5  rt field
- in_imm  in  26  immediate / shift amount / branch target, two's complement
- in_last  in  1  final instruction of session
- imem_we  out  1  write strobe
- imem_addr  out  AW  write address
- imem_wdata  out  32  encoded word
- words_written  out  AW+1  words written this session
- done  out  1  one-cycle pulse, session complete
- err_illegal  out  1  sticky; illegal mnemonic seen this session
- err_range  out  1  sticky; immediate out of field range this session

## Operation
- Mnemonic codes 0–21: add, comp, and, xor, shll, shrl, shllv, shrlv, shra, shrav, addi, compi, lw, sw, b, br, bltz, bz, bnz, bl, bcy, bncy. Codes 22–31 are illegal.
- R-type (codes 0–9): opcode 0. funct = 0,1,2,3,4,5,6,7,8,9 in listed order. Word = {6'b0, rs[25:21], rt[20:16], sh[15:11], 5'b0, funct[5:0]}. sh = in_imm[4:0] for shll/shrl/shra, 0 otherwise.
- Opcodes: addi 1, compi 2, lw 3, sw 4, b 5, br 6, bltz 7, bz 8, bnz 9, bl 10, bcy 11, bncy 12. funct field is not present.
- addi, compi, lw, sw: {op, rs, rt, imm[15:0]}. rt = 0 for addi/compi.
- br: {op, rs, 21'b0}.
- bltz, bz, bnz: {op, rs, imm[20:0]}.
- b, bl, bcy, bncy: {op, imm[25:0]}.
- Range check:
  - 16-bit field: in_imm[25:15] all equal.
  - 21-bit field: in_imm[25:20] all equal.
  - Shift amount: in_imm[25:5] == 0.
  - On violation the truncated word is still written and err_range is set.
- Illegal mnemonic: the instruction is consumed, nothing is written, the pointer and count are unchanged, and err_illegal is set.
- FSM states IDLE, LOAD, DONE:
  - IDLE → LOAD on start.
  - LOAD → DONE on a handshake with in_last=1, or on a handshake that writes address 2^AW−1.
  - DONE → IDLE after one cycle.
  - start in any state → LOAD. The write pointer is reloaded, count and error flags are cleared, and an in-flight registered write still completes.
- in_ready = (state==LOAD) & ~start.
- The write pointer wraps modulo 2^AW only via a new start; reaching the top address ends the session.

## Timing
- Reset values: state IDLE, in_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, words_written 0, done 0, err_illegal 0, err_range 0.
- Latency is one cycle. A handshake in cycle N gives imem_we=1 with the addr/wdata of that instruction in cycle N+1, and words_written increments in cycle N+1.
- Throughput is one instruction per cycle; there is no backpressure from memory.
- done is high in the cycle the final word's imem_we is high. If the final instruction is illegal, done is high in N+1 with imem_we low.
- Error flags assert in N+1 and hold until the next start or reset.
- Reset asserted mid-session returns all outputs to reset values immediately. A pending write is lost.

## Structure
- Package kgp_isa_pkg holds:
  - mnemonic code constants;
  - opcode and funct constants, shared with the decoder;
  - field bit positions;
  - the FSM state typedef.
- Sub-module kgp_word_pack: combinational mnemonic+operands → {word, illegal, range_err}. The top level holds the FSM, pointer, counter and output registers.

## Test plan
- start base=0x010; stream add r1,r2; addi r3,#−5; lw r4,8(r5) with in_last → writes 0x00220000 @0x010, 0x0460FFFB @0x011, 0x0CA40008 @0x012. done is with the third write; words_written=3.
- Stream shra r7,#3 then bz r2,L=−4 → 0x00E01808, then 0x205FFFFC.
- addi with imm=40000 → err_range=1, word written with imm[15:0]=0x9C40. Mnemonic 25 → no write, err_illegal=1, count unchanged.
- base=2^AW−2, in_valid held high with no in_last → exactly two writes (0x3FE, 0x3FF), done, then in_ready=0.
- start asserted during a session, coincident with in_valid → that instruction is not accepted, the prior accepted word is still written, and flags and count clear.
- rst_n pulsed low mid-stream → all outputs 0 asynchronously. A new session starting from start behaves normally.

Source files
------------

// File: rtl/kgp_isa_pkg.sv
// KGP-RISC ISA constants shared by the instruction encoder and the control decoder.
// Holds mnemonic codes, opcode/funct values, field positions and the loader FSM state type.
package kgp_isa_pkg;

    // Mnemonic codes presented on the host stream; codes above MN_BNCY are illegal
    localparam logic [4:0] MN_ADD   = 5'd0;
    localparam logic [4:0] MN_COMP  = 5'd1;
    localparam logic [4:0] MN_AND   = 5'd2;
    localparam logic [4:0] MN_XOR   = 5'd3;
    localparam logic [4:0] MN_SHLL  = 5'd4;
    localparam logic [4:0] MN_SHRL  = 5'd5;
    localparam logic [4:0] MN_SHLLV = 5'd6;
    localparam logic [4:0] MN_SHRLV = 5'd7;
    localparam logic [4:0] MN_SHRA  = 5'd8;
    localparam logic [4:0] MN_SHRAV = 5'd9;
    localparam logic [4:0] MN_ADDI  = 5'd10;
    localparam logic [4:0] MN_COMPI = 5'd11;
    localparam logic [4:0] MN_LW    = 5'd12;
    localparam logic [4:0] MN_SW    = 5'd13;
    localparam logic [4:0] MN_B     = 5'd14;
    localparam logic [4:0] MN_BR    = 5'd15;
    localparam logic [4:0] MN_BLTZ  = 5'd16;
    localparam logic [4:0] MN_BZ    = 5'd17;
    localparam logic [4:0] MN_BNZ   = 5'd18;
    localparam logic [4:0] MN_BL    = 5'd19;
    localparam logic [4:0] MN_BCY   = 5'd20;
    localparam logic [4:0] MN_BNCY  = 5'd21;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_COMPI = 6'd2;
    localparam logic [5:0] OP_LW    = 6'd3;
    localparam logic [5:0] OP_SW    = 6'd4;
    localparam logic [5:0] OP_B     = 6'd5;
    localparam logic [5:0] OP_BR    = 6'd6;
    localparam logic [5:0] OP_BLTZ  = 6'd7;
    localparam logic [5:0] OP_BZ    = 6'd8;
    localparam logic [5:0] OP_BNZ   = 6'd9;
    localparam logic [5:0] OP_BL    = 6'd10;
    localparam logic [5:0] OP_BCY   = 6'd11;
    localparam logic [5:0] OP_BNCY  = 6'd12;

    localparam logic [5:0] FN_ADD   = 6'd0;
    localparam logic [5:0] FN_COMP  = 6'd1;
    localparam logic [5:0] FN_AND   = 6'd2;
    localparam logic [5:0] FN_XOR   = 6'd3;
    localparam logic [5:0] FN_SHLL  = 6'd4;
    localparam logic [5:0] FN_SHRL  = 6'd5;
    localparam logic [5:0] FN_SHLLV = 6'd6;
    localparam logic [5:0] FN_SHRLV = 6'd7;
    localparam logic [5:0] FN_SHRA  = 6'd8;
    localparam logic [5:0] FN_SHRAV = 6'd9;

    // Instruction word field positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int SH_MSB    = 15;
    localparam int SH_LSB    = 11;
    localparam int FN_MSB    = 5;
    localparam int FN_LSB    = 0;
    localparam int IMM16_MSB = 15;
    localparam int IMM21_MSB = 20;
    localparam int IMM26_MSB = 25;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    function automatic logic [5:0] r_funct(input logic [4:0] m);
        logic [5:0] f;
        f = FN_ADD;
        case (m)
            MN_COMP:  f = FN_COMP;
            MN_AND:   f = FN_AND;
            MN_XOR:   f = FN_XOR;
            MN_SHLL:  f = FN_SHLL;
            MN_SHRL:  f = FN_SHRL;
            MN_SHLLV: f = FN_SHLLV;
            MN_SHRLV: f = FN_SHRLV;
            MN_SHRA:  f = FN_SHRA;
            MN_SHRAV: f = FN_SHRAV;
            default:  f = FN_ADD;
        endcase
        return f;
    endfunction

    function automatic logic [5:0] i_opcode(input logic [4:0] m);
        logic [5:0] op;
        op = OP_RTYPE;
        case (m)
            MN_ADDI:  op = OP_ADDI;
            MN_COMPI: op = OP_COMPI;
            MN_LW:    op = OP_LW;
            MN_SW:    op = OP_SW;
            MN_B:     op = OP_B;
            MN_BR:    op = OP_BR;
            MN_BLTZ:  op = OP_BLTZ;
            MN_BZ:    op = OP_BZ;
            MN_BNZ:   op = OP_BNZ;
            MN_BL:    op = OP_BL;
            MN_BCY:   op = OP_BCY;
            MN_BNCY:  op = OP_BNCY;
            default:  op = OP_RTYPE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/kgp_word_pack.sv
// Combinational packer: mnemonic + operands -> 32-bit KGP-RISC word, illegal and range flags.
// Zero latency; no flow control of its own.
module kgp_word_pack
    import kgp_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_err
);

    logic fits16;
    logic fits21;
    logic shamt_ok;

    // Sign-extension checks: the dropped upper bits must all match the field's sign bit
    assign fits16   = (&imm[25:15]) | ~(|imm[25:15]);
    assign fits21   = (&imm[25:20]) | ~(|imm[25:20]);
    assign shamt_ok = ~(|imm[25:5]);

    always_comb begin
        word      = '0;
        illegal   = 1'b0;
        range_err = 1'b0;
        word[OP_MSB:OP_LSB] = i_opcode(mnem);
        case (mnem)
            MN_ADD, MN_COMP, MN_AND, MN_XOR, MN_SHLLV, MN_SHRLV, MN_SHRAV: begin
                word[RS_MSB:RS_LSB] = rs;
                word[RT_MSB:RT_LSB] = rt;
                word[FN_MSB:FN_LSB] = r_funct(mnem);
            end
            MN_SHLL, MN_SHRL, MN_SHRA: begin
                word[RS_MSB:RS_LSB] = rs;
                word[RT_MSB:RT_LSB] = rt;
                word[SH_MSB:SH_LSB] = imm[4:0];
                word[FN_MSB:FN_LSB] = r_funct(mnem);
                range_err           = ~shamt_ok;
            end
            MN_ADDI, MN_COMPI: begin
                word[RS_MSB:RS_LSB]  = rs;
                word[IMM16_MSB:0]    = imm[IMM16_MSB:0];
                range_err            = ~fits16;
            end
            MN_LW, MN_SW: begin
                word[RS_MSB:RS_LSB]  = rs;
                word[RT_MSB:RT_LSB]  = rt;
                word[IMM16_MSB:0]    = imm[IMM16_MSB:0];
                range_err            = ~fits16;
            end
            MN_BR: begin
                word[RS_MSB:RS_LSB]  = rs;
            end
            MN_BLTZ, MN_BZ, MN_BNZ: begin
                word[RS_MSB:RS_LSB]  = rs;
                word[IMM21_MSB:0]    = imm[IMM21_MSB:0];
                range_err            = ~fits21;
            end
            MN_B, MN_BL, MN_BCY, MN_BNCY: begin
                word[IMM26_MSB:0]    = imm[IMM26_MSB:0];
            end
            default: begin
                word    = '0;
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/kgp_instr_encoder.sv
// Instruction loader: packs streamed symbolic instructions and writes them to imem from base_addr.
// One-cycle latency, one instruction per cycle; in_ready drops outside LOAD and while start is high.
module kgp_instr_encoder
    import kgp_isa_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_mnem,
    input  logic [4:0]    in_rs,
    input  logic [4:0]    in_rt,
    input  logic [25:0]   in_imm,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wdata,
    output logic [AW:0]   words_written,
    output logic          done,
    output logic          err_illegal,
    output logic          err_range
);

    enc_state_e    state_q;
    enc_state_e    state_d;
    logic [AW-1:0] ptr_q;
    logic [AW:0]   cnt_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          err_ill_q;
    logic          err_rng_q;

    logic [31:0]   pk_word;
    logic          pk_illegal;
    logic          pk_range;
    logic          hs;
    logic          wr;
    logic          finish;

    kgp_word_pack u_pack (
        .mnem      (in_mnem),
        .rs        (in_rs),
        .rt        (in_rt),
        .imm       (in_imm),
        .word      (pk_word),
        .illegal   (pk_illegal),
        .range_err (pk_range)
    );

    assign in_ready = (state_q == ST_LOAD) & ~start;
    assign hs       = in_valid & in_ready;
    assign wr       = hs & ~pk_illegal;
    // Writing the top address ends the session; the pointer never wraps inside a session
    assign finish   = hs & (in_last | (~pk_illegal & (ptr_q == {AW{1'b1}})));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_IDLE;
            ST_LOAD: if (finish) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (start) state_d = ST_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_ill_q <= 1'b0;
            err_rng_q <= 1'b0;
        end else begin
            // The write register is independent of start so an in-flight write still lands
            we_q <= wr;
            if (wr) begin
                addr_q  <= ptr_q;
                wdata_q <= pk_word;
            end
            if (start) begin
                ptr_q     <= base_addr;
                cnt_q     <= '0;
                err_ill_q <= 1'b0;
                err_rng_q <= 1'b0;
            end else if (hs) begin
                if (pk_illegal) begin
                    err_ill_q <= 1'b1;
                end else begin
                    ptr_q <= ptr_q + AW'(1);
                    cnt_q <= cnt_q + (AW+1)'(1);
                    if (pk_range) err_rng_q <= 1'b1;
                end
            end
        end
    end

    assign imem_we       = we_q;
    assign imem_addr     = addr_q;
    assign imem_wdata    = wdata_q;
    assign words_written = cnt_q;
    assign done          = (state_q == ST_DONE);
    assign err_illegal   = err_ill_q;
    assign err_range     = err_rng_q;

endmodule

// File: tb/tb_kgp_instr_encoder.sv
// Scoreboard bench for kgp_instr_encoder: directed instruction vectors with hand-computed words.
module tb_kgp_instr_encoder;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_mnem;
    logic [4:0]    in_rs;
    logic [4:0]    in_rt;
    logic [25:0]   in_imm;
    logic          in_last;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   words_written;
    logic          done;
    logic          err_illegal;
    logic          err_range;

    always #5 clk = ~clk;

    kgp_instr_encoder #(.AW(AW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .base_addr     (base_addr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mnem       (in_mnem),
        .in_rs         (in_rs),
        .in_rt         (in_rt),
        .in_imm        (in_imm),
        .in_last       (in_last),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .words_written (words_written),
        .done          (done),
        .err_illegal   (err_illegal),
        .err_range     (err_range)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic          dn;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp = 0;
    int            n_mis = 0;
    logic [AW-1:0] exp_ptr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: every DUT write must match the oldest scoreboard entry
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_write: addr 0x%03h data 0x%08h, expected no write", imem_addr, imem_wdata);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
                check("wr_done", 32'(done), 32'(e.dn));
            end
        end
    end

    task automatic check_zero_outputs();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_words_written", 32'(words_written), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_illegal", 32'(err_illegal), 32'd0);
        check("rst_err_range", 32'(err_range), 32'd0);
    endtask

    // Called at posedge+1; leaves the session in LOAD at posedge+1
    task automatic start_session(input logic [AW-1:0] b);
        start     = 1'b1;
        base_addr = b;
        exp_ptr   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Presents one instruction and pushes its expected write once the handshake is certain
    task automatic send(input logic [4:0] m, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [25:0] imm, input logic last, input logic legal,
                        input logic [31:0] word, input logic exp_done);
        int w;
        w        = 0;
        in_mnem  = m;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_mis++;
            $display("FAIL handshake_timeout: in_ready=%b, expected 1 within 20 cycles", in_ready);
        end else if (legal) begin
            sb.push_back('{addr: exp_ptr, data: word, dn: exp_done});
            exp_ptr = exp_ptr + AW'(1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int hs_cnt;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        in_valid  = 1'b0;
        in_mnem   = '0;
        in_rs     = '0;
        in_rt     = '0;
        in_imm    = '0;
        in_last   = 1'b0;
        #2;
        check_zero_outputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // add r1,r2 ; addi r3,#-5 ; lw r4,8(r5) last
        start_session(10'h010);
        send(5'd0,  5'd1, 5'd2, 26'd0,        1'b0, 1'b1, 32'h0022_0000, 1'b0);
        send(5'd10, 5'd3, 5'd0, 26'h3FF_FFFB, 1'b0, 1'b1, 32'h0460_FFFB, 1'b0);
        send(5'd12, 5'd5, 5'd4, 26'd8,        1'b1, 1'b1, 32'h0CA4_0008, 1'b1);
        @(negedge clk);
        check("s1_words_written", 32'(words_written), 32'd3);
        check("s1_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        check("s1_idle_in_ready", 32'(in_ready), 32'd0);
        check("s1_idle_done", 32'(done), 32'd0);
        check("s1_count_hold", 32'(words_written), 32'd3);

        // shra r7,#3 ; bz r2,-4 ; addi out of range ; illegal ; add last
        start_session(10'h100);
        send(5'd8,  5'd7, 5'd0, 26'd3,        1'b0, 1'b1, 32'h00E0_1808, 1'b0);
        send(5'd17, 5'd2, 5'd0, 26'h3FF_FFFC, 1'b0, 1'b1, 32'h205F_FFFC, 1'b0);
        @(negedge clk);
        check("s2_err_range_clear", 32'(err_range), 32'd0);
        @(posedge clk);
        #1;
        send(5'd10, 5'd1, 5'd0, 26'd40000,    1'b0, 1'b1, 32'h0420_9C40, 1'b0);
        @(negedge clk);
        check("s2_err_range_set", 32'(err_range), 32'd1);
        check("s2_err_illegal_clear", 32'(err_illegal), 32'd0);
        check("s2_words_written", 32'(words_written), 32'd3);
        @(posedge clk);
        #1;
        send(5'd25, 5'd1, 5'd1, 26'd0,        1'b0, 1'b0, 32'h0,         1'b0);
        @(negedge clk);
        check("s2_err_illegal_set", 32'(err_illegal), 32'd1);
        check("s2_count_after_illegal", 32'(words_written), 32'd3);
        @(posedge clk);
        #1;
        send(5'd0,  5'd0, 5'd0, 26'd0,        1'b1, 1'b1, 32'h0000_0000, 1'b1);
        @(negedge clk);
        check("s2_err_range_sticky", 32'(err_range), 32'd1);
        check("s2_words_final", 32'(words_written), 32'd4);
        @(posedge clk);
        #1;

        // Top-of-memory: in_valid held, no in_last
        start_session(10'h3FE);
        in_mnem  = 5'd0;
        in_rs    = 5'd1;
        in_rt    = 5'd1;
        in_imm   = '0;
        in_last  = 1'b0;
        in_valid = 1'b1;
        hs_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                sb.push_back('{addr: exp_ptr, data: 32'h0021_0000, dn: (exp_ptr == 10'h3FF)});
                exp_ptr = exp_ptr + AW'(1);
                hs_cnt++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("s3_handshakes", 32'(hs_cnt), 32'd2);
        check("s3_in_ready_after", 32'(in_ready), 32'd0);
        check("s3_words_written", 32'(words_written), 32'd2);

        // start during a session, coincident with in_valid
        start_session(10'h020);
        send(5'd25, 5'd0, 5'd0, 26'd0,        1'b0, 1'b0, 32'h0,         1'b0);
        send(5'd0,  5'd1, 5'd2, 26'd0,        1'b0, 1'b1, 32'h0022_0000, 1'b0);
        start     = 1'b1;
        base_addr = 10'h040;
        in_mnem   = 5'd10;
        in_rs     = 5'd3;
        in_rt     = 5'd0;
        in_imm    = 26'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        check("s4_ready_blocked", 32'(in_ready), 32'd0);
        check("s4_inflight_count", 32'(words_written), 32'd1);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        exp_ptr  = 10'h040;
        @(negedge clk);
        check("s4_count_cleared", 32'(words_written), 32'd0);
        check("s4_err_illegal_cleared", 32'(err_illegal), 32'd0);
        @(posedge clk);
        #1;
        send(5'd14, 5'd0, 5'd0, 26'h200_0010, 1'b1, 1'b1, 32'h1600_0010, 1'b1);

        // Asynchronous reset mid-stream
        @(posedge clk);
        #1;
        start_session(10'h050);
        send(5'd3,  5'd4, 5'd5, 26'd0,        1'b0, 1'b1, 32'h0085_0003, 1'b0);
        in_mnem  = 5'd0;
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_zero_outputs();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("s5_idle_after_reset", 32'(in_ready), 32'd0);
        start_session(10'h060);
        send(5'd15, 5'd9, 5'd0, 26'd0,        1'b1, 1'b1, 32'h1920_0000, 1'b1);
        @(negedge clk);
        check("s5_words_written", 32'(words_written), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
